// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host-transmitter state type, frame length and keyboard command bytes
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, RELEASE} ps2_tx_state_t;
  localparam int PS2_FRAME_BITS = 10;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for one PS/2 line, optional glitch filter, falling-edge pulse
// Ports: clk, rst (async active-high, line idles high); line raw level;
// level synchronized (optionally filtered) level; fall one-cycle pulse on a 1->0 of level.
// Macro PS2_TX_FILTER_EN: level only changes after 8 consecutive equal synchronized samples.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);
  logic [1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      prev <= level;
    end
`ifdef PS2_TX_FILTER_EN
  logic [2:0] run;
  logic filt;
  // run counts consecutive samples that disagree with filt; the 8th one flips it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run  <= '0;
      filt <= 1'b1;
    end else if (sync[1] == filt) begin
      run <= '0;
    end else if (run == 3'd7) begin
      run  <= '0;
      filt <= sync[1];
    end else begin
      run <= run + 3'd1;
    end
  assign level = filt;
`else
  assign level = sync[1];
`endif
  assign fall = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ACK check)
// Ports: clk_in, rst_in (async active-high); tx_data/tx_valid/tx_ready byte handshake;
// ps2_clk_in/ps2_data_in raw line levels; ps2_clk_oe/ps2_data_oe open-drain pull-low enables;
// done/error one-cycle completion pulses; busy high whenever not IDLE.
// Macro PS2_TX_FILTER_EN (in ps2_line_sync) adds an 8-sample glitch filter on both lines.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 7425,
  parameter int TIMEOUT_CYCLES = 148500
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error,
  output logic       busy
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  ps2_tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_n;
  logic [8:0] sh, sh_n;
  logic dat, dat_n, done_n, err_n, watch;
  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  ps2_line_sync u_clk_sync (.clk(clk_in), .rst(rst_in), .line(ps2_clk_in), .level(clk_lvl), .fall(clk_fall));
  ps2_line_sync u_data_sync (.clk(clk_in), .rst(rst_in), .line(ps2_data_in), .level(data_lvl), .fall(data_fall_unused));
  // cnt is the inhibit timer in INHIBIT and the edge/release watchdog afterwards
  assign watch = state != IDLE && state != INHIBIT;
  assign ps2_clk_oe = state == INHIBIT;
  // start bit goes low on the last inhibit cycle, before the clock line is released
  assign ps2_data_oe = dat | (state == INHIBIT && cnt == CW'(INHIBIT_CYCLES - 1));
  assign busy = state != IDLE;
  assign tx_ready = state == IDLE && !done && !error;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      dat     <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      dat     <= dat_n;
      done    <= done_n;
      error   <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? '0 : cnt + CW'(1);
    bit_n = bit_cnt;
    sh_n = sh;
    dat_n = dat;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n = INHIBIT;
        sh_n = {odd_parity(tx_data), tx_data};
        bit_n = '0;
      end
      INHIBIT: if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
        state_n = REQUEST;
        dat_n = 1'b1;
      end
      REQUEST: if (clk_fall) begin
        state_n = SEND;
        dat_n = ~sh[0];
        bit_n = 4'd1;
      end
      SEND: if (clk_fall) begin
        cnt_n = '0;
        if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
          state_n = ACK;
          dat_n = 1'b0;
          bit_n = 4'(PS2_FRAME_BITS);
        end else begin
          dat_n = ~sh[bit_cnt];
          bit_n = bit_cnt + 4'd1;
        end
      end
      ACK: if (clk_fall) begin
        state_n = data_lvl ? IDLE : RELEASE;
        err_n = data_lvl;
      end
      RELEASE: if (clk_lvl && data_lvl) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (watch && state_n == state && !clk_fall && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      dat_n = 1'b0;
      err_n = 1'b1;
    end
    if (state_n != state) cnt_n = '0;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a frame-level PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int N = 20, T = 300, HALF = 15;
  logic clk = 1'b0, rst_in = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, done, error, busy;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  int cyc = 0, acc = -1, dev_start = -1, exp_err_cyc = -1, last_err_cyc = -1;
  int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk), .rst_in(rst_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .done(done), .error(error), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // line levels the device sees, LSB first: 8 data bits, odd parity, stop (high)
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  always @(negedge clk) begin
    if (done) n_done++;
    if (error) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if (!rst_in) begin
      chk("clk_oe_window", int'(ps2_clk_oe), int'(acc >= 0 && cyc >= acc && cyc < acc + N));
      if (acc >= 0 && cyc >= acc && cyc < acc + N - 1) chk("inhibit_data_oe", int'(ps2_data_oe), 0);
      if (acc >= 0 && cyc >= acc + N - 1 && cyc <= dev_start) chk("start_bit_oe", int'(ps2_data_oe), 1);
      if (acc >= 0 && cyc >= acc && cyc <= dev_start) chk("busy_in_frame", int'(busy), 1);
      chk("ready_while_busy", int'(tx_ready & busy), 0);
      chk("done_and_error", int'(done & error), 0);
      if (exp_err_cyc >= 0 && cyc == exp_err_cyc) begin
        chk("timeout_error", int'(error), 1);
        chk("timeout_oe", int'(ps2_clk_oe | ps2_data_oe), 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    acc = cyc + 1;
    dev_start = acc + N + T - 1;
    if (!hold) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_req();
    while (cyc < acc + N + 5) @(negedge clk);
  endtask

  task automatic dev_frame(input bit ack, input int edges, output logic [9:0] rx);
    rx = '0;
    dev_start = cyc;
    for (int k = 0; k < edges; k++) begin
      dev_data_low = ack && k == 10;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k < 10) rx[k] = ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int limit);
    int i = 0;
    while (n_done == d0 && n_err == e0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("end_within_limit", int'(i < limit), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] rx;
    int d0, e0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'(ps2_clk_oe | ps2_data_oe), 0);
    chk("rst_pulses", int'(done | error), 0);
    @(negedge clk);
    rst_in = 1'b0;
    repeat (5) @(negedge clk);

    d0 = n_done; e0 = n_err;
    send(PS2_CMD_SET_LEDS, 1'b0);
    wait_req();
    dev_frame(1'b1, 11, rx);
    chk("ed_frame", int'(rx), int'(exp_frame(PS2_CMD_SET_LEDS)));
    chk("ed_literal", int'(rx), 'h3ED);
    wait_end(d0, e0, 200);
    chk("ed_done_count", n_done - d0, 1);
    chk("ed_error_count", n_err - e0, 0);

    d0 = n_done; e0 = n_err;
    send(8'h01, 1'b0);
    wait_req();
    dev_frame(1'b0, 11, rx);
    chk("noack_frame", int'(rx), int'(exp_frame(8'h01)));
    chk("noack_literal", int'(rx), 'h201);
    wait_end(d0, e0, 200);
    chk("noack_error_count", n_err - e0, 1);
    chk("noack_done_count", n_done - d0, 0);
    chk("noack_released", int'(ps2_clk_oe | ps2_data_oe), 0);

    d0 = n_done; e0 = n_err;
    send(PS2_CMD_RESET, 1'b0);
    exp_err_cyc = acc + N + T;
    wait_end(d0, e0, N + T + 50);
    chk("tmo_cycle", last_err_cyc, acc + N + T);
    chk("tmo_error_count", n_err - e0, 1);
    chk("tmo_done_count", n_done - d0, 0);
    exp_err_cyc = -1;

    d0 = n_done; e0 = n_err;
    send(8'h00, 1'b1);
    wait_req();
    dev_frame(1'b1, 11, rx);
    chk("held_frame", int'(rx), int'(exp_frame(8'h00)));
    chk("held_literal", int'(rx), 'h300);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    tx_valid = 1'b0;
    repeat (N + 10) @(negedge clk);
    chk("held_done_count", n_done - d0, 1);
    chk("held_error_count", n_err - e0, 0);
    chk("held_idle", int'(busy), 0);

    d0 = n_done; e0 = n_err;
    send(8'hA5, 1'b0);
    wait_req();
    dev_frame(1'b0, 5, rx);
    chk("mid_bits", int'(rx[4:0]), 'h05);
    chk("pre_rst_data_oe", int'(ps2_data_oe), 1);
    @(negedge clk);
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_oe", int'(ps2_clk_oe | ps2_data_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_pulse", (n_done - d0) + (n_err - e0), 0);

    d0 = n_done; e0 = n_err;
    send(8'h5A, 1'b0);
    wait_req();
    dev_frame(1'b1, 11, rx);
    chk("after_rst_frame", int'(rx), int'(exp_frame(8'h5A)));
    chk("after_rst_literal", int'(rx), 'h35A);
    wait_end(d0, e0, 200);
    chk("after_rst_done_count", n_done - d0, 1);

    d0 = n_done; e0 = n_err;
    send(8'h3C, 1'b0);
    wait_req();
`ifdef PS2_TX_FILTER_EN
    exp_err_cyc = acc + N + T;
`endif
    dev_start = cyc;
    for (int g = 0; g < 11; g++) begin
      dev_clk_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
    end
    wait_end(d0, e0, N + T + 50);
`ifdef PS2_TX_FILTER_EN
    chk("glitch_filtered_tmo", last_err_cyc, acc + N + T);
`else
    chk("glitch_advances", int'(last_err_cyc < acc + N + T), 1);
`endif
    chk("glitch_error_count", n_err - e0, 1);
    chk("glitch_done_count", n_done - d0, 0);
    exp_err_cyc = -1;

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
